// File: rtl/memblock_exerciser.sv
// Self-test engine for a NOR-style set/reset memory block: walks x/y through a
// fixed 12-step table, samples q/nq via a 2-flop synchronizer and tallies mismatches.
module memblock_exerciser #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q,
  input  logic       nq,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] fail_step,
  output logic [3:0] step_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd11;
  localparam logic [3:0] NO_FAIL   = 4'hF;

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       q_s1, q_s, nq_s1, nq_s;
  logic [4:0] entry;
  logic       mismatch;

  // Entry layout: {check, x, y, expected q, expected nq}
  function automatic logic [4:0] step_entry(input logic [3:0] idx);
    logic [4:0] e;
    case (idx)
      4'd0:    e = 5'b1_01_01;
      4'd1:    e = 5'b1_00_01;
      4'd2:    e = 5'b1_10_10;
      4'd3:    e = 5'b1_00_10;
      4'd4:    e = 5'b1_10_10;
      4'd5:    e = 5'b1_11_00;
      4'd6:    e = 5'b1_01_01;
      4'd7:    e = 5'b1_11_00;
      4'd8:    e = 5'b1_10_10;
      4'd9:    e = 5'b1_11_00;
      4'd10:   e = 5'b0_00_00;
      4'd11:   e = 5'b1_01_01;
      default: e = 5'b0_00_00;
    endcase
    return e;
  endfunction

  assign entry    = step_entry(step_idx);
  assign mismatch = entry[4] && ({q_s, nq_s} != entry[1:0]);

  assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign pass = done && (err_count == 4'd0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_DRIVE;
      S_DRIVE:        state_nx = S_WAIT;
      S_WAIT:         if (wait_cnt == 4'd1) state_nx = S_CHECK;
      S_CHECK:        state_nx = (step_idx == LAST_STEP) ? S_DONE : S_DRIVE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x         <= 1'b0;
      y         <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      fail_step <= NO_FAIL;
      step_idx  <= '0;
      wait_cnt  <= '0;
      q_s1      <= 1'b0;
      q_s       <= 1'b0;
      nq_s1     <= 1'b0;
      nq_s      <= 1'b0;
    end else begin
      state <= state_nx;
      q_s1  <= q;
      q_s   <= q_s1;
      nq_s1 <= nq;
      nq_s  <= nq_s1;
      // done is a registered view of the DONE state; a restart drops it on the start edge
      done  <= (state == S_DONE) && !start;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= '0;
            fail_step <= NO_FAIL;
            step_idx  <= '0;
          end
        end
        S_DRIVE: begin
          x        <= entry[3];
          y        <= entry[2];
          wait_cnt <= 4'(SETTLE);
        end
        S_WAIT: wait_cnt <= wait_cnt - 4'd1;
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != 4'hF) err_count <= err_count + 4'd1;
            if (fail_step == NO_FAIL) fail_step <= step_idx;
          end
          if (state_nx == S_DRIVE) step_idx <= step_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
